// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the CPU data-memory bus. Zero-latency reads and one-edge writes
//   into a word-organised RAM with byte/halfword lanes and sign/zero extension. Also
//   provides a 16-byte MMIO debug window: LED, CYCLES, STORES and STATUS (sticky
//   misalignment flag, write-1-to-clear).
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   mem_w    write strobe for the current access
//   addr     byte address of the current access
//   din      store data, LSB-aligned
//   dm_type  000 word, 001 half, 010 half-u, 011 byte, 100 byte-u, others reserved
//   dout     load data (combinational)
//   led_out  LED register
//   err_out  sticky misalignment flag
module data_mem_responder #(
  parameter int          ADDR_WIDTH = 7,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_F000,
  parameter int          LED_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_w,
  input  logic [31:0]          addr,
  input  logic [31:0]          din,
  input  logic [2:0]           dm_type,
  output logic [31:0]          dout,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 err_out
);

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_CYCLES = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic [31:0] ram [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           rd_word;
  logic                  mmio_sel;
  logic                  misaligned;
  logic                  accept_w;
  logic [31:0]           ram_rd;
  logic [31:0]           mmio_rd;
  logic [31:0]           wr_word;
  logic [15:0]           half;
  logic [7:0]            byte_l;

  logic [LED_WIDTH-1:0]  led;
  logic [31:0]           cycles;
  logic [31:0]           stores;
  logic                  err;
  logic [31:0]           last_bad_addr;

  assign idx      = addr[ADDR_WIDTH+1:2];
  assign rd_word  = ram[idx];
  assign mmio_sel = (addr[31:4] == MMIO_BASE[31:4]);
  assign half     = addr[1] ? rd_word[31:16] : rd_word[15:0];
  assign byte_l   = rd_word[8*addr[1:0] +: 8];

  // MMIO is word-only; reserved types are always treated as misaligned.
  always_comb begin
    misaligned = 1'b0;
    case (dm_type)
      DM_W:         misaligned = (addr[1:0] != 2'b00);
      DM_H, DM_HU:  misaligned = addr[0] | mmio_sel;
      DM_B, DM_BU:  misaligned = mmio_sel;
      default:      misaligned = 1'b1;
    endcase
  end

  assign accept_w = mem_w & ~misaligned;

  always_comb begin
    ram_rd = rd_word;
    case (dm_type)
      DM_H:    ram_rd = {{16{half[15]}}, half};
      DM_HU:   ram_rd = {16'h0, half};
      DM_B:    ram_rd = {{24{byte_l[7]}}, byte_l};
      DM_BU:   ram_rd = {24'h0, byte_l};
      default: ram_rd = rd_word;
    endcase
  end

  always_comb begin
    mmio_rd = 32'h0;
    case (addr[3:2])
      OFF_LED:    mmio_rd = 32'(led);
      OFF_CYCLES: mmio_rd = cycles;
      2'd2:       mmio_rd = stores;
      default:    mmio_rd = {31'h0, err};
    endcase
  end

  assign dout = misaligned ? 32'h0 : (mmio_sel ? mmio_rd : ram_rd);

  // Sub-word stores merge into the current word so untouched lanes survive.
  always_comb begin
    wr_word = rd_word;
    case (dm_type)
      DM_H, DM_HU: wr_word[16*addr[1] +: 16]  = din[15:0];
      DM_B, DM_BU: wr_word[8*addr[1:0] +: 8]  = din[7:0];
      default:     wr_word = din;
    endcase
  end

  // RAM has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (accept_w && !mmio_sel && !rst) ram[idx] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led           <= '0;
      cycles        <= '0;
      stores        <= '0;
      err           <= 1'b0;
      last_bad_addr <= '0;
    end else begin
      // A CYCLES write takes priority over the free-running increment.
      if (accept_w && mmio_sel && addr[3:2] == OFF_CYCLES) cycles <= '0;
      else                                                 cycles <= cycles + 32'd1;
      if (accept_w) stores <= stores + 32'd1;
      if (accept_w && mmio_sel && addr[3:2] == OFF_LED) led <= din[LED_WIDTH-1:0];
      if (misaligned) begin
        err           <= 1'b1;
        last_bad_addr <= addr;
      end else if (accept_w && mmio_sel && addr[3:2] == OFF_STATUS && din[0]) begin
        err <= 1'b0;
      end
    end
  end

  assign led_out = led;
  assign err_out = err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-addressed reference model, random traffic,
// and directed literal checks.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_w = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;
  logic [2:0]  dm_type = 3'b000;
  logic [31:0] dout;
  logic [15:0] led_out;
  logic        err_out;

  data_mem_responder dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .addr(addr), .din(din),
    .dm_type(dm_type), .dout(dout), .led_out(led_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit init_done = 1'b0;

  // Model state: byte-wide memory plus the MMIO registers.
  logic [7:0]  mb [0:511];
  logic [15:0] m_led = 16'h0;
  logic [31:0] m_cyc = 32'h0;
  logic [31:0] m_st = 32'h0;
  logic        m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:4] == 28'h0000F00;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] t);
    if (t > 3'd4) return 1'b1;
    if (is_mmio(a) && t != 3'd0) return 1'b1;
    if (t == 3'd0) return a[1:0] != 2'b00;
    if (t == 3'd1 || t == 3'd2) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] t);
    int b;
    logic [15:0] h;
    b = int'(a[8:0]);
    if (is_mis(a, t)) return 32'h0;
    if (is_mmio(a)) begin
      case (a[3:2])
        2'd0: return {16'h0, m_led};
        2'd1: return m_cyc;
        2'd2: return m_st;
        default: return {31'h0, m_err};
      endcase
    end
    case (t)
      3'd0: return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      3'd1, 3'd2: begin
        h = {mb[b+1], mb[b]};
        return (t == 3'd1 && h[15]) ? {16'hFFFF, h} : {16'h0, h};
      end
      default: return (t == 3'd3 && mb[b][7]) ? {24'hFFFFFF, mb[b]} : {24'h0, mb[b]};
    endcase
  endfunction

  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] t);
    int b;
    bit clr;
    b = int'(a[8:0]);
    clr = 1'b0;
    if (is_mis(a, t)) m_err = 1'b1;
    else if (w) begin
      m_st = m_st + 1;
      if (is_mmio(a)) begin
        case (a[3:2])
          2'd0: m_led = d[15:0];
          2'd1: clr = 1'b1;
          2'd3: if (d[0]) m_err = 1'b0;
          default: ;
        endcase
      end else begin
        case (t)
          3'd0: for (int k = 0; k < 4; k++) mb[b+k] = d[8*k +: 8];
          3'd1, 3'd2: begin mb[b] = d[7:0]; mb[b+1] = d[15:8]; end
          default: mb[b] = d[7:0];
        endcase
      end
    end
    m_cyc = clr ? 32'h0 : m_cyc + 1;
  endtask

  task automatic model_reset();
    m_led = 16'h0; m_cyc = 32'h0; m_st = 32'h0; m_err = 1'b0;
  endtask

  task automatic set_in(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] t);
    mem_w = w; addr = a; din = d; dm_type = t;
  endtask

  // Advance one edge; inputs change at posedge+1, away from the negedge monitor.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step(mem_w, addr, din, dm_type);
    #1;
  endtask

  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] t);
    set_in(w, a, d, t);
    tick();
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [2:0] t,
                        input logic [31:0] exp);
    set_in(1'b0, a, 32'h0, t);
    #2;
    check(name, dout, exp);
    tick();
  endtask

  task automatic do_reset();
    set_in(1'b0, 32'h0, 32'h0, 3'd0);
    rst = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Single compare process: every negedge, outputs against the model.
  always @(negedge clk) begin
    if (init_done || is_mmio(addr) || is_mis(addr, dm_type))
      check("dout", dout, model_read(addr, dm_type));
    check("led_out", {16'h0, led_out}, {16'h0, m_led});
    check("err_out", {31'h0, err_out}, {31'h0, m_err});
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0] t;
    logic w;
    int kind;

    do_reset();
    // Fill RAM so every later read is defined.
    for (int i = 0; i < 128; i++) cyc(1'b1, 32'(i * 4), $urandom, 3'd0);
    init_done = 1'b1;

    // Cycle counter after reset release, and write-clears-wins.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 32'h0, 3'd0);
    chk_rd("cycles_10", 32'hF004, 3'd0, 32'd10);
    cyc(1'b1, 32'hF004, 32'h5555_AAAA, 3'd0);
    chk_rd("cycles_clr0", 32'hF004, 3'd0, 32'd0);
    chk_rd("cycles_clr1", 32'hF004, 3'd0, 32'd1);

    do_reset();
    // Word store/load and store counter.
    cyc(1'b1, 32'h10, 32'hDEADBEEF, 3'd0);
    chk_rd("lw_10", 32'h10, 3'd0, 32'hDEADBEEF);
    chk_rd("stores_1", 32'hF008, 3'd0, 32'd1);
    // Byte store into the top lane.
    cyc(1'b1, 32'h10, 32'h11223344, 3'd0);
    cyc(1'b1, 32'h13, 32'h0000_0080, 3'd3);
    chk_rd("sb_word", 32'h10, 3'd0, 32'h80223344);
    chk_rd("lb_13", 32'h13, 3'd3, 32'hFFFFFF80);
    chk_rd("lbu_13", 32'h13, 3'd4, 32'h00000080);
    // Half store into the upper lane.
    cyc(1'b1, 32'h20, 32'h55667788, 3'd0);
    cyc(1'b1, 32'h22, 32'h0000ABCD, 3'd1);
    chk_rd("lh_22", 32'h22, 3'd1, 32'hFFFFABCD);
    chk_rd("lhu_22", 32'h22, 3'd2, 32'h0000ABCD);
    chk_rd("lh_20", 32'h20, 3'd1, 32'h00007788);
    // Misaligned store: suppressed, flags error, dout forced to zero.
    set_in(1'b1, 32'h11, 32'hCAFEF00D, 3'd0);
    #2;
    check("mis_dout", dout, 32'h0);
    tick();
    check("mis_err", {31'h0, err_out}, 32'd1);
    chk_rd("mis_ram", 32'h10, 3'd0, 32'h80223344);
    chk_rd("status_1", 32'hF00C, 3'd0, 32'd1);
    chk_rd("stores_5", 32'hF008, 3'd0, 32'd5);
    chk_rd("mmio_sub", 32'hF000, 3'd2, 32'h0);
    cyc(1'b1, 32'hF00C, 32'd1, 3'd0);
    check("w1c_err", {31'h0, err_out}, 32'd0);
    // LED write, then asynchronous reset mid-cycle.
    cyc(1'b1, 32'hF000, 32'h12345678, 3'd0);
    check("led", {16'h0, led_out}, 32'h5678);
    set_in(1'b0, 32'hF004, 32'h0, 3'd0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_led", {16'h0, led_out}, 32'h0);
    check("rst_cycles", dout, 32'h0);
    addr = 32'hF008;
    #1;
    check("rst_stores", dout, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      kind = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      if (kind < 2) begin
        a = 32'hF000 | 32'($urandom_range(0, 3) * 4);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(0, 3));
        if (a[3:2] == 2'd2) w = 1'b0;
        if ($urandom_range(0, 1) == 0) t = 3'd0;
      end else begin
        a = $urandom;
        if (is_mmio(a)) a[16] = ~a[16];
        if (t == 3'd0 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        if ((t == 3'd1 || t == 3'd2) && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      end
      cyc(w, a, d, t);
    end

    set_in(1'b0, 32'h0, 32'h0, 3'd0);
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
